// File: rtl/err_compute_gen.sv
// Serial position-weighted IR error engine: snapshots NUM_PAIRS right/left
// readings, accumulates sum((R[i]-L[i]) << i) over 2*NUM_PAIRS cycles, then
// optionally inverts, saturates and registers the result with a valid pulse.
module err_compute_gen #(
  parameter int unsigned NUM_PAIRS = 4,
  parameter int unsigned IR_W      = 12,
  parameter int unsigned ERR_W     = 16,
  parameter int unsigned INVERT    = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      IR_vld,
  input  logic [NUM_PAIRS*IR_W-1:0] IR_R,
  input  logic [NUM_PAIRS*IR_W-1:0] IR_L,
  output logic [ERR_W-1:0]          error,
  output logic                      err_vld,
  output logic                      sat,
  output logic                      busy,
  output logic                      ovr
);

  localparam int unsigned IN_W   = NUM_PAIRS * IR_W;
  localparam int unsigned ACC_W  = IR_W + NUM_PAIRS + 1;
  localparam int unsigned PAIR_W = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
  localparam int unsigned CMP_W  = ((ACC_W > ERR_W) ? ACC_W : ERR_W) + 1;

  // Clamp limits, sign-extended to the comparison width
  localparam logic signed [CMP_W-1:0] MAX_V = {{(CMP_W-ERR_W+1){1'b0}}, {(ERR_W-1){1'b1}}};
  localparam logic signed [CMP_W-1:0] MIN_V = {{(CMP_W-ERR_W+1){1'b1}}, {(ERR_W-1){1'b0}}};

  typedef enum logic {IDLE, ACCUM} state_e;

  state_e                   state_q, state_d;
  logic [PAIR_W-1:0]        pair_q, pair_d;
  logic                     phase_q, phase_d;   // 0: add right, 1: subtract left
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [IN_W-1:0]          r_snap_q, r_snap_d;
  logic [IN_W-1:0]          l_snap_q, l_snap_d;
  logic [ERR_W-1:0]         error_q, error_d;
  logic                     sat_q, sat_d;
  logic                     err_vld_q, err_vld_d;
  logic                     busy_q, busy_d;
  logic                     ovr_q, ovr_d;

  logic [IR_W-1:0]          rd_sel;
  logic signed [ACC_W-1:0]  term;
  logic signed [ACC_W-1:0]  acc_step;
  logic signed [ACC_W-1:0]  fin;
  logic signed [CMP_W-1:0]  fin_ext;
  logic                     last_step;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pair_q    <= '0;
      phase_q   <= 1'b0;
      acc_q     <= '0;
      r_snap_q  <= '0;
      l_snap_q  <= '0;
      error_q   <= '0;
      sat_q     <= 1'b0;
      err_vld_q <= 1'b0;
      busy_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pair_q    <= pair_d;
      phase_q   <= phase_d;
      acc_q     <= acc_d;
      r_snap_q  <= r_snap_d;
      l_snap_q  <= l_snap_d;
      error_q   <= error_d;
      sat_q     <= sat_d;
      err_vld_q <= err_vld_d;
      busy_q    <= busy_d;
      ovr_q     <= ovr_d;
    end
  end

  // Next-state, accumulation step, inversion and saturation
  always_comb begin
    state_d   = state_q;
    pair_d    = pair_q;
    phase_d   = phase_q;
    acc_d     = acc_q;
    r_snap_d  = r_snap_q;
    l_snap_d  = l_snap_q;
    error_d   = error_q;
    sat_d     = sat_q;
    err_vld_d = 1'b0;
    busy_d    = busy_q;
    ovr_d     = 1'b0;

    rd_sel    = phase_q ? l_snap_q[int'(pair_q)*IR_W +: IR_W]
                        : r_snap_q[int'(pair_q)*IR_W +: IR_W];
    term      = ACC_W'(rd_sel) << pair_q;
    acc_step  = phase_q ? (acc_q - term) : (acc_q + term);
    fin       = (INVERT != 0) ? -acc_step : acc_step;
    fin_ext   = {{(CMP_W-ACC_W){fin[ACC_W-1]}}, fin};
    last_step = phase_q && (pair_q == PAIR_W'(NUM_PAIRS - 1));

    case (state_q)
      IDLE: begin
        if (IR_vld) begin
          r_snap_d = IR_R;
          l_snap_d = IR_L;
          acc_d    = '0;
          pair_d   = '0;
          phase_d  = 1'b0;
          busy_d   = 1'b1;
          state_d  = ACCUM;
        end
      end
      ACCUM: begin
        acc_d   = acc_step;
        ovr_d   = IR_vld;
        phase_d = ~phase_q;
        if (phase_q) pair_d = pair_q + PAIR_W'(1);
        if (last_step) begin
          state_d   = IDLE;
          busy_d    = 1'b0;
          pair_d    = '0;
          err_vld_d = 1'b1;
          if (fin_ext > MAX_V) begin
            error_d = MAX_V[ERR_W-1:0];
            sat_d   = 1'b1;
          end else if (fin_ext < MIN_V) begin
            error_d = MIN_V[ERR_W-1:0];
            sat_d   = 1'b1;
          end else begin
            error_d = fin_ext[ERR_W-1:0];
            sat_d   = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign error   = error_q;
  assign sat     = sat_q;
  assign err_vld = err_vld_q;
  assign busy    = busy_q;
  assign ovr     = ovr_q;

endmodule
